// File: rtl/cpu_control_if.sv
// Bus between the fetch/sequence stage and its neighbours: program load pins,
// ALU status/branch indications in, instruction and status out.
interface cpu_control_if #(
   parameter int unsigned PC_W = 4,
   parameter int unsigned OP_W = 2,
   parameter int unsigned AD_W = 4
);
   logic            prog_en;
   logic            prog_bit;
   logic            run;
   logic            carry;
   logic            borrow;
   logic            bcf;
   logic            bbf;
   logic            buc;
   logic [OP_W-1:0] opcode;
   logic [AD_W-1:0] addrs;
   logic            exec_stb;
   logic [PC_W-1:0] pc;
   logic            carry_flag;
   logic            borrow_flag;
   logic            word_wr;

   modport master (
      output prog_en, prog_bit, run, carry, borrow, bcf, bbf, buc,
      input  opcode, addrs, exec_stb, pc, carry_flag, borrow_flag, word_wr
   );

   modport slave (
      input  prog_en, prog_bit, run, carry, borrow, bcf, bbf, buc,
      output opcode, addrs, exec_stb, pc, carry_flag, borrow_flag, word_wr
   );
endinterface

// File: rtl/cpu_control.sv
// Fetch/sequence stage: serially loaded 16-word program store, 4-bit PC,
// instruction register toward the ALU, carry/borrow flags and branch resolution.
module cpu_control #(
   parameter int unsigned PC_W = 4,
   parameter int unsigned OP_W = 2,
   parameter int unsigned AD_W = 4
) (
   input logic          clk,
   input logic          rst,
   cpu_control_if.slave bus
);
   localparam int unsigned IW    = OP_W + AD_W;
   localparam int unsigned DEPTH = 1 << PC_W;
   localparam int unsigned BC_W  = $clog2(IW);

   typedef enum logic [1:0] {IDLE, LOAD, FETCH, EXEC} state_t;

   state_t          state;
   state_t          nextState;
   logic [IW-1:0]   store [DEPTH];
   logic [IW-2:0]   shiftReg;
   logic [BC_W-1:0] bitCnt;
   logic [PC_W-1:0] loadPtr;
   logic            loadEntry;
   logic            shiftEn;
   logic            wordDone;
   logic            isBranch;
   logic            taken;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state decode plus load/branch qualifiers
   always_comb begin
      nextState = state;
      loadEntry = 1'b0;
      shiftEn   = 1'b0;
      wordDone  = 1'b0;
      isBranch  = bus.bcf | bus.bbf | bus.buc;
      taken     = bus.buc | (bus.bcf & bus.carry_flag) | (bus.bbf & bus.borrow_flag);
      case (state)
         IDLE:    if (bus.prog_en) nextState = LOAD;
                  else if (bus.run) nextState = FETCH;
         LOAD:    if (!bus.prog_en) nextState = IDLE;
         FETCH:   if (bus.prog_en) nextState = LOAD;
                  else nextState = EXEC;
         EXEC:    if (bus.prog_en) nextState = LOAD;
                  else if (bus.run) nextState = FETCH;
                  else nextState = IDLE;
         default: nextState = IDLE;
      endcase
      loadEntry = bus.prog_en && (state != LOAD);
      shiftEn   = bus.prog_en && (state == LOAD);
      wordDone  = shiftEn && (bitCnt == BC_W'(IW - 1));
   end

   // Strobe decoded straight from the state register
   assign bus.exec_stb = (state == EXEC);

   // Program store: cleared on reset, written when a full serial word arrives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) store[i] <= '0;
      end else if (wordDone) begin
         store[loadPtr] <= {shiftReg, bus.prog_bit};
      end
   end

   // Load datapath, instruction register, PC and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shiftReg        <= '0;
         bitCnt          <= '0;
         loadPtr         <= '0;
         bus.pc          <= '0;
         bus.opcode      <= '0;
         bus.addrs       <= '0;
         bus.carry_flag  <= 1'b0;
         bus.borrow_flag <= 1'b0;
         bus.word_wr     <= 1'b0;
      end else begin
         bus.word_wr <= wordDone;
         if (loadEntry) begin
            bitCnt          <= '0;
            loadPtr         <= '0;
            bus.pc          <= '0;
            bus.carry_flag  <= 1'b0;
            bus.borrow_flag <= 1'b0;
         end else if (shiftEn) begin
            shiftReg <= {shiftReg[IW-3:0], bus.prog_bit};
            if (wordDone) begin
               bitCnt  <= '0;
               loadPtr <= loadPtr + PC_W'(1);
            end else begin
               bitCnt <= bitCnt + BC_W'(1);
            end
         end else if (state == FETCH) begin
            {bus.opcode, bus.addrs} <= store[bus.pc];
         end else if (state == EXEC) begin
            bus.pc <= taken ? PC_W'(bus.addrs) : bus.pc + PC_W'(1);
            if (!isBranch) begin
               bus.carry_flag  <= bus.carry;
               bus.borrow_flag <= bus.borrow;
            end
         end
      end
   end
endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: a reference model predicts each executed instruction,
// pushes it to a scoreboard queue, and a monitor pops/compares on every EXEC.
module tb_cpu_control;
   typedef struct packed {
      logic [1:0] op;
      logic [3:0] ad;
      logic [3:0] pc;
      logic       cf;
      logic       bf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   nCmp  = 0;
   int   nFail = 0;

   logic [5:0] mstore [16];
   logic [3:0] mpc;
   logic [3:0] mptr;
   logic       mcf;
   logic       mbf;
   exp_t       q[$];

   always #5 clk = ~clk;

   cpu_control_if bus ();
   cpu_control dut (.clk(clk), .rst(rst), .bus(bus));

   // Scoreboard monitor: every EXEC cycle must match the oldest prediction
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.exec_stb) begin
         if (q.size() == 0) begin
            nCmp++; nFail++;
            $display("FAIL sb_empty: unexpected EXEC at pc=%0d", bus.pc);
         end else begin
            e = q.pop_front();
            nCmp++; if (bus.opcode !== e.op) begin nFail++; $display("FAIL sb_opcode: got %0d want %0d (pc %0d)", bus.opcode, e.op, e.pc); end
            nCmp++; if (bus.addrs !== e.ad) begin nFail++; $display("FAIL sb_addrs: got %0d want %0d (pc %0d)", bus.addrs, e.ad, e.pc); end
            nCmp++; if (bus.pc !== e.pc) begin nFail++; $display("FAIL sb_pc: got %0d want %0d", bus.pc, e.pc); end
            nCmp++; if (bus.carry_flag !== e.cf) begin nFail++; $display("FAIL sb_carry_flag: got %b want %b (pc %0d)", bus.carry_flag, e.cf, e.pc); end
            nCmp++; if (bus.borrow_flag !== e.bf) begin nFail++; $display("FAIL sb_borrow_flag: got %b want %b (pc %0d)", bus.borrow_flag, e.bf, e.pc); end
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mstore[i] = 6'd0;
      mpc = 4'd0; mptr = 4'd0; mcf = 1'b0; mbf = 1'b0;
   endtask

   // Predict one instruction, run until its EXEC cycle, then present ALU indications
   task automatic issue(input logic c, input logic b, input logic bc, input logic bb,
                        input logic bu, output int lat);
      exp_t e;
      logic tk;
      e.op = mstore[mpc][5:4];
      e.ad = mstore[mpc][3:0];
      e.pc = mpc;
      e.cf = mcf;
      e.bf = mbf;
      q.push_back(e);
      bus.run = 1'b1;
      lat = 0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (bus.exec_stb) begin lat = i; break; end
      end
      if (lat == 0) begin
         nCmp++; nFail++;
         $display("FAIL exec_timeout: no EXEC within 4 cycles, want pc %0d", e.pc);
         void'(q.pop_back());
      end
      bus.carry = c; bus.borrow = b; bus.bcf = bc; bus.bbf = bb; bus.buc = bu;
      tk = bu | (bc & mcf) | (bb & mbf);
      if (!(bc | bb | bu)) begin mcf = c; mbf = b; end
      mpc = tk ? e.ad : mpc + 4'd1;
   endtask

   task automatic stop_run();
      bus.run = 1'b0;
      @(negedge clk);
   endtask

   task automatic enter_load();
      bus.run = 1'b0;
      bus.prog_en = 1'b1;
      @(negedge clk);
      mpc = 4'd0; mptr = 4'd0; mcf = 1'b0; mbf = 1'b0;
   endtask

   // Shift one word MSB first; returns word_wr seen after each bit
   task automatic shift_word(input logic [5:0] w, output logic [5:0] wr);
      for (int i = 5; i >= 0; i--) begin
         bus.prog_bit = w[i];
         @(negedge clk);
         wr[i] = bus.word_wr;
      end
      mstore[mptr] = w;
      mptr = mptr + 4'd1;
   endtask

   task automatic leave_load();
      bus.prog_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.prog_en = 0; bus.prog_bit = 0; bus.run = 0;
      bus.carry = 0; bus.borrow = 0; bus.bcf = 0; bus.bbf = 0; bus.buc = 0;
      model_reset();
      repeat (3) @(negedge clk);
      nCmp++; if ({bus.opcode, bus.addrs, bus.pc} !== 10'd0) begin nFail++; $display("FAIL reset_instr_pc: got %h want 0", {bus.opcode, bus.addrs, bus.pc}); end
      nCmp++; if ({bus.exec_stb, bus.carry_flag, bus.borrow_flag, bus.word_wr} !== 4'd0) begin nFail++; $display("FAIL reset_status: got %b want 0000", {bus.exec_stb, bus.carry_flag, bus.borrow_flag, bus.word_wr}); end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nCmp++; if (bus.exec_stb !== 1'b0) begin nFail++; $display("FAIL reset_idle_stb: cycle %0d got %b want 0", i, bus.exec_stb); end
      end
   endtask

   task automatic test_load();
      logic [5:0] wr;
      int lat;
      enter_load();
      shift_word(6'b100101, wr);
      nCmp++; if (wr !== 6'b000001) begin nFail++; $display("FAIL load_wr0: got %b want 000001", wr); end
      shift_word(6'b010011, wr);
      nCmp++; if (wr !== 6'b000001) begin nFail++; $display("FAIL load_wr1: got %b want 000001", wr); end
      leave_load();
      issue(0, 0, 0, 0, 0, lat);
      nCmp++; if ({bus.opcode, bus.addrs} !== {2'd2, 4'd5}) begin nFail++; $display("FAIL load_exec1: got op %0d ad %0d want 2/5", bus.opcode, bus.addrs); end
      issue(0, 0, 0, 0, 0, lat);
      nCmp++; if ({bus.opcode, bus.addrs} !== {2'd1, 4'd3}) begin nFail++; $display("FAIL load_exec2: got op %0d ad %0d want 1/3", bus.opcode, bus.addrs); end
      nCmp++; if (lat != 2) begin nFail++; $display("FAIL exec_spacing: got %0d cycles want 2", lat); end
      stop_run();
   endtask

   task automatic test_seq_wrap();
      logic [5:0] wr;
      logic [5:0] w;
      int lat;
      enter_load();
      for (int k = 0; k < 17; k++) begin
         w = 6'($urandom_range(0, 63));
         shift_word(w, wr);
         nCmp++; if (wr !== 6'b000001) begin nFail++; $display("FAIL seq_load_wr: word %0d got %b want 000001", k, wr); end
      end
      leave_load();
      for (int k = 0; k < 17; k++) begin
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, lat);
         nCmp++; if (bus.pc !== 4'(k % 16)) begin nFail++; $display("FAIL seq_pc: step %0d got %0d want %0d", k, bus.pc, k % 16); end
      end
      stop_run();
   endtask

   task automatic test_branch();
      logic [5:0] tbl [16];
      logic [5:0] wr;
      int lat;
      for (int i = 0; i < 16; i++) tbl[i] = {2'(i), ~4'(i)};
      tbl[3]  = 6'b11_1010;
      tbl[7]  = 6'b00_1100;
      tbl[8]  = 6'b11_0010;
      tbl[10] = 6'b01_0111;
      tbl[12] = 6'b10_0111;
      enter_load();
      for (int i = 0; i < 16; i++) shift_word(tbl[i], wr);
      leave_load();
      issue(0, 0, 0, 0, 0, lat);           // pc0
      issue(0, 0, 0, 0, 0, lat);           // pc1
      issue(0, 0, 0, 0, 0, lat);           // pc2
      issue(1, 1, 0, 0, 1, lat);           // pc3: buc to 0xA, flags hold
      issue(0, 0, 1, 0, 0, lat);           // pc10: bcf with carry_flag 0
      nCmp++; if ({bus.pc, bus.carry_flag, bus.borrow_flag} !== {4'd10, 2'b00}) begin nFail++; $display("FAIL buc_target: got pc %0d cf %b bf %b want 10/0/0", bus.pc, bus.carry_flag, bus.borrow_flag); end
      issue(1, 0, 0, 0, 0, lat);           // pc11: sets carry_flag
      nCmp++; if (bus.pc !== 4'd11) begin nFail++; $display("FAIL bcf_not_taken: got pc %0d want 11", bus.pc); end
      issue(0, 0, 1, 0, 0, lat);           // pc12: bcf taken to 7
      issue(0, 0, 0, 1, 0, lat);           // pc7: bbf with borrow_flag 0
      nCmp++; if (bus.pc !== 4'd7) begin nFail++; $display("FAIL bcf_taken: got pc %0d want 7", bus.pc); end
      issue(0, 0, 1, 1, 0, lat);           // pc8: bcf|bbf, carry_flag 1 -> 2
      nCmp++; if (bus.pc !== 4'd8) begin nFail++; $display("FAIL bbf_not_taken: got pc %0d want 8", bus.pc); end
      issue(0, 0, 0, 0, 0, lat);           // pc2
      nCmp++; if (bus.pc !== 4'd2) begin nFail++; $display("FAIL multi_branch: got pc %0d want 2", bus.pc); end
      stop_run();
   endtask

   task automatic test_prog_abort();
      logic [5:0] wr;
      int lat;
      issue(1, 1, 0, 0, 0, lat);
      issue(1, 1, 0, 0, 0, lat);
      nCmp++; if ({bus.carry_flag, bus.borrow_flag} !== 2'b11) begin nFail++; $display("FAIL abort_pre_flags: got %b want 11", {bus.carry_flag, bus.borrow_flag}); end
      bus.run = 1'b0;
      bus.prog_en = 1'b1;
      @(negedge clk);
      mpc = 4'd0; mptr = 4'd0; mcf = 1'b0; mbf = 1'b0;
      nCmp++; if ({bus.pc, bus.carry_flag, bus.borrow_flag} !== 6'd0) begin nFail++; $display("FAIL abort_load_clear: got pc %0d cf %b bf %b want 0/0/0", bus.pc, bus.carry_flag, bus.borrow_flag); end
      for (int i = 0; i < 3; i++) begin
         bus.prog_bit = 1'b1;
         @(negedge clk);
         wr[i] = bus.word_wr;
      end
      bus.prog_en = 1'b0;
      @(negedge clk);
      wr[3] = bus.word_wr;
      nCmp++; if (wr[3:0] !== 4'd0) begin nFail++; $display("FAIL abort_word_wr: got %b want 0000", wr[3:0]); end
      nCmp++; if (bus.exec_stb !== 1'b0) begin nFail++; $display("FAIL abort_idle: exec_stb got %b want 0", bus.exec_stb); end
      issue(0, 0, 0, 0, 0, lat);
      nCmp++; if (lat != 2) begin nFail++; $display("FAIL abort_restart: got %0d cycles want 2", lat); end
      stop_run();
   endtask

   task automatic test_async_reset();
      int lat;
      issue(1, 1, 0, 0, 0, lat);
      issue(0, 0, 0, 0, 0, lat);
      #2 rst = 1'b1;
      #1;
      nCmp++; if ({bus.opcode, bus.addrs, bus.pc} !== 10'd0) begin nFail++; $display("FAIL async_rst_instr_pc: got %h want 0", {bus.opcode, bus.addrs, bus.pc}); end
      nCmp++; if ({bus.exec_stb, bus.carry_flag, bus.borrow_flag, bus.word_wr} !== 4'd0) begin nFail++; $display("FAIL async_rst_status: got %b want 0000", {bus.exec_stb, bus.carry_flag, bus.borrow_flag, bus.word_wr}); end
      bus.run = 1'b0;
      bus.carry = 0; bus.borrow = 0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nCmp++; if (bus.exec_stb !== 1'b0) begin nFail++; $display("FAIL async_rst_idle: cycle %0d got %b want 0", i, bus.exec_stb); end
      end
      issue(0, 0, 0, 0, 0, lat);
      stop_run();
   endtask

   initial begin
      test_reset();
      test_load();
      test_seq_wrap();
      test_branch();
      test_prog_abort();
      test_async_reset();
      repeat (2) @(negedge clk);
      nCmp++; if (q.size() != 0) begin nFail++; $display("FAIL sb_leftover: %0d predictions never executed", q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end
endmodule
